// File: rtl/uart_pkg.sv
// Shared types and helpers for the hex-dump UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} tx_state_t;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // Upper-case ASCII for one hex digit ('A' - 10 = 0x37).
  function automatic logic [7:0] hex2ascii(input logic [3:0] nib);
    return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser; byte_ready in the last stop-bit cycle lets callers chain bytes with no gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       tx
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state, state_nx;
  logic [CW-1:0] baud_cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_nx;
  logic [7:0]    shreg, sh_nx;
  logic          tx_q, tx_nx;
  logic          wrap;

  assign wrap = (baud_cnt == LAST);
  assign tx   = tx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= cnt_nx;
      bit_idx  <= bit_nx;
      shreg    <= sh_nx;
      tx_q     <= tx_nx;
    end
  end

  // tx_nx is the line level for the next cycle, so the pin comes straight off a flop.
  always_comb begin
    state_nx   = state;
    cnt_nx     = wrap ? '0 : baud_cnt + 1'b1;
    bit_nx     = bit_idx;
    sh_nx      = shreg;
    tx_nx      = tx_q;
    byte_ready = 1'b0;
    case (state)
      IDLE: begin
        byte_ready = 1'b1;
        cnt_nx     = '0;
        tx_nx      = 1'b1;
        if (byte_valid) begin
          state_nx = START_BIT;
          sh_nx    = byte_data;
          tx_nx    = 1'b0;
        end
      end
      START_BIT: begin
        if (wrap) begin
          state_nx = DATA_BITS;
          bit_nx   = '0;
          tx_nx    = shreg[0];
        end
      end
      DATA_BITS: begin
        if (wrap) begin
          if (bit_idx == 3'd7) begin
            state_nx = STOP_BIT;
            tx_nx    = 1'b1;
          end else begin
            bit_nx = bit_idx + 3'd1;
            sh_nx  = shreg >> 1;
            tx_nx  = shreg[1];
          end
        end
      end
      STOP_BIT: begin
        if (wrap) begin
          byte_ready = 1'b1;
          if (byte_valid) begin
            state_nx = START_BIT;
            sh_nx    = byte_data;
            tx_nx    = 1'b0;
          end else begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        tx_nx    = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/uart_hex_tx.sv
// Sends a captured 32-bit word as 8 upper-case hex characters plus CR LF over 8N1 serial.
module uart_hex_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] data,
  output logic        busy,
  output logic        done,
  output logic        rs232_tx
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

  logic [31:0] shift_word;
  logic [3:0]  char_idx;
  logic        accept, byte_valid, byte_ready;
  logic [7:0]  byte_data, next_char;

  assign accept = start & ~busy;

  // shift_word[27:24] always holds the nibble for char_idx+1; char 0 goes straight from data.
  always_comb begin
    next_char = ASCII_LF;
    if (char_idx < 4'd7)       next_char = hex2ascii(shift_word[27:24]);
    else if (char_idx == 4'd7) next_char = ASCII_CR;
  end

  assign byte_valid = accept | (busy & (char_idx != 4'd9));
  assign byte_data  = accept ? hex2ascii(data[31:28]) : next_char;

  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      shift_word <= '0;
      char_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        shift_word <= data;
        char_idx   <= '0;
        busy       <= 1'b1;
      end else if (busy && byte_ready) begin
        if (char_idx == 4'd9) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          char_idx   <= char_idx + 4'd1;
          shift_word <= shift_word << 4;
        end
      end
    end
  end

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk       (CLK100MHZ),
    .rst_n     (rst_n),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .byte_ready(byte_ready),
    .tx        (rs232_tx)
  );

endmodule

// File: tb/tb_uart_hex_tx.sv
// Bench for uart_hex_tx at 16 clocks per bit: table vectors, random words, and multi-cycle corner cases.
module tb_uart_hex_tx;

  localparam int CPB   = 16;
  localparam int FRAME = 100 * CPB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] data = '0;
  logic        busy, done, tx;

  int checks = 0;
  int failures = 0;
  logic smp [FRAME];

  typedef struct packed {
    logic [31:0] d;
    logic [79:0] exp;
  } vec_t;
  vec_t tbl [4];

  uart_hex_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
    .CLK100MHZ(clk),
    .rst_n    (rst_n),
    .start    (start),
    .data     (data),
    .busy     (busy),
    .done     (done),
    .rs232_tx (tx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference text for a word: 8 hex digits MSB first, then CR LF.
  function automatic logic [79:0] model(input logic [31:0] w);
    logic [79:0] r = '0;
    for (int i = 0; i < 8; i++) begin
      int n = int'((w >> (28 - 4 * i)) & 32'hF);
      logic [7:0] ch = (n < 10) ? 8'(48 + n) : 8'(65 + n - 10);
      r = {r[71:0], ch};
    end
    return {r[63:0], 8'h0D, 8'h0A};
  endfunction

  // Expected line level for frame bit k (10 bits per character, LSB first).
  function automatic logic line_bit(input logic [79:0] txt, input int k);
    int c = k / 10;
    int p = k % 10;
    logic [7:0] ch = 8'(txt >> (8 * (9 - c)));
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return ch[p-1];
  endfunction

  task automatic kick(input logic [31:0] d, input string nm);
    start = 1'b1;
    data  = d;
    step();
    start = 1'b0;
    data  = $urandom();
    chk({nm, "_busy_rise"}, 80'(busy), 80'd1);
    chk({nm, "_start_bit"}, 80'(tx), 80'd0);
  endtask

  // Entered in cycle N+1 of an accepted frame; leaves after the done cycle.
  task automatic frame(input logic [79:0] exp, input string nm, input int pulse_at,
                       input bit chain, input logic [31:0] nd);
    int bad_busy = 0;
    int early_done = 0;
    int bad_bits = 0;
    logic [79:0] got = '0;
    for (int j = 0; j < FRAME; j++) begin
      smp[j] = tx;
      if (busy !== 1'b1) bad_busy++;
      if (done !== 1'b0) early_done++;
      if (j == pulse_at) begin
        start = 1'b1;
        data  = 32'h22222222;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    chk({nm, "_busy_held"}, 80'(bad_busy), 80'd0);
    chk({nm, "_no_early_done"}, 80'(early_done), 80'd0);
    chk({nm, "_done_pulse"}, 80'(done), 80'd1);
    chk({nm, "_busy_fall"}, 80'(busy), 80'd0);
    chk({nm, "_idle_line"}, 80'(tx), 80'd1);
    for (int j = 0; j < FRAME; j++)
      if (smp[j] !== line_bit(exp, j / CPB)) bad_bits++;
    chk({nm, "_line_bits"}, 80'(bad_bits), 80'd0);
    for (int c = 0; c < 10; c++) begin
      logic [7:0] rx;
      for (int b = 0; b < 8; b++) rx[b] = smp[(c * 10 + 1 + b) * CPB + CPB / 2];
      got = {got[71:0], rx};
    end
    chk({nm, "_decoded"}, got, exp);
    if (chain) begin
      kick(nd, {nm, "_b2b"});
    end else begin
      step();
      chk({nm, "_done_single"}, 80'({done, busy, tx}), 80'(3'b001));
    end
  endtask

  initial begin
    tbl[0] = '{32'h1234ABCD, "1234ABCD\r\n"};
    tbl[1] = '{32'h00000000, "00000000\r\n"};
    tbl[2] = '{32'hFFFFFFFF, "FFFFFFFF\r\n"};
    tbl[3] = '{32'h9A09A09A, "9A09A09A\r\n"};

    rst_n = 1'b0;
    repeat (5) step();
    chk("reset_outputs", 80'({tx, busy, done}), 80'(3'b100));
    rst_n = 1'b1;
    begin
      int act = 0;
      for (int i = 0; i < 100; i++) begin
        if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) act++;
        step();
      end
      chk("idle_quiet", 80'(act), 80'd0);
    end

    for (int i = 0; i < 4; i++) begin
      string nm = $sformatf("vec%0d", i);
      kick(tbl[i].d, nm);
      frame(tbl[i].exp, nm, -1, 1'b0, 32'h0);
    end

    // Start pulse at cycle N+500 must be ignored.
    kick(32'h11111111, "ignore");
    frame("11111111\r\n", "ignore", 499, 1'b0, 32'h0);

    // Async reset at cycle N+700 kills the frame at once.
    kick(32'h55555555, "midrst");
    repeat (699) step();
    rst_n = 1'b0;
    #1;
    chk("midrst_immediate", 80'({tx, busy, done}), 80'(3'b100));
    repeat (3) step();
    chk("midrst_held", 80'({tx, busy, done}), 80'(3'b100));
    rst_n = 1'b1;
    step();
    kick(32'hDEADBEEF, "after_rst");
    frame("DEADBEEF\r\n", "after_rst", -1, 1'b1, 32'hCAFEF00D);
    frame("CAFEF00D\r\n", "b2b", -1, 1'b0, 32'h0);

    for (int i = 0; i < 5; i++) begin
      logic [31:0] w = $urandom();
      string nm = $sformatf("rand%0d", i);
      kick(w, nm);
      frame(model(w), nm, -1, 1'b0, 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_hex_tx.md
Name: uart_hex_tx

Overview:
Debug transmitter for the on-board monitor. The board display shows the current debug word; this block sends the same kind of word to the host PC over the RS-232 line.
On a start pulse it captures a 32-bit word and serialises it as 8 upper-case ASCII hex characters (MSB nibble first), then CR and LF.
Framing is 8N1. It sits beside the UART receive path and drives rs232_tx.

Parameters:
CLK_FREQ, 100000000, input clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
CLKS_PER_BIT, CLK_FREQ/BAUD (868), cycles per serial bit. Derived localparam; must be >= 2.

Ports:
CLK100MHZ  input  1  system clock; all logic on the rising edge.
rst_n  input  1  asynchronous, active-low reset.
start  input  1  request to send one frame; sampled only when busy=0.
data  input  32  word to send; captured in the cycle start is accepted.
busy  output  1  high from the cycle after acceptance until the frame ends.
done  output  1  one-cycle pulse when the last stop bit completes.
rs232_tx  output  1  serial line; idles high.

Behaviour:
- Reset (async, rst_n=0): rs232_tx=1, busy=0, done=0, FSM=IDLE, all counters 0. Takes effect immediately, including mid-frame; no partial character is completed.
- Acceptance: start=1 while busy=0 in cycle N. Then data is latched into shift_word, char_idx=0, and in cycle N+1: busy=1, rs232_tx=0 (start bit).
- start while busy=1 is ignored. data changes after acceptance have no effect.
- Character sequence, char_idx 0..9:
  - idx 0..7 send nibble (7-idx) of the latched word.
  - Nibble 0-9 maps to 0x30-0x39; nibble A-F maps to 0x41-0x46.
  - idx 8 sends 0x0D; idx 9 sends 0x0A.
- Per character: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit lasts exactly CLKS_PER_BIT cycles, timed by baud_cnt, which counts 0..CLKS_PER_BIT-1 and wraps.
- No idle gap between characters: the start bit of char k+1 begins in the cycle after the last cycle of char k's stop bit.
- FSM states:
  - IDLE: rs232_tx=1. On start, go to START_BIT.
  - START_BIT: go to DATA_BITS at the baud wrap.
  - DATA_BITS: bit_idx runs 0..7; go to STOP_BIT at the baud wrap with bit_idx=7.
  - STOP_BIT: at the baud wrap, if char_idx<9, increment char_idx and go to START_BIT; else go to IDLE.
- Completion: the frame is 100 bits long. In cycle N+1+100*CLKS_PER_BIT: done=1 for one cycle, busy=0, rs232_tx=1.
- Back-to-back: start asserted in the done cycle is accepted (busy=0 there), so the next start bit follows with zero idle cycles.
- rs232_tx is driven from a register (glitch-free). done and busy are also registered.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum tx_state_t {IDLE, START_BIT, DATA_BITS, STOP_BIT}.
  - ASCII_CR=8'h0D and ASCII_LF=8'h0A.
  - Function hex2ascii(logic [3:0]) returning logic [7:0].
- One natural sub-module, uart_byte_tx: a byte serialiser with baud counter and byte_valid/byte_ready.
  - byte_ready is high in IDLE and in the final cycle of STOP_BIT, giving the zero-gap chaining above.
  - uart_hex_tx keeps the capture register, char_idx, and the busy/done generation.

Test Plan:
- Reset values: hold rst_n=0 for 5 cycles -> rs232_tx=1, busy=0, done=0. Release and hold start=0 for 100 cycles -> no line activity.
- Basic frame, CLK_FREQ=16 and BAUD=1 (16 cycles/bit): start with data=32'h1234ABCD -> bench UART decoder receives 31 32 33 34 41 42 43 44 0D 0A. done pulses exactly at cycle N+1+1600. busy is high for exactly 1600 cycles.
- Digit boundaries: data=32'h00000000 -> eight 0x30 then 0D 0A. data=32'hFFFFFFFF -> eight 0x46. data=32'h9A09A09A -> 39 41 30 39 41 30 39 41.
- Ignore while busy: start with 32'h11111111, then pulse start with 32'h22222222 at cycle N+500 -> only "11111111\r\n" is sent and done pulses once.
- Reset mid-frame: assert rst_n=0 at cycle N+700 -> rs232_tx=1 and busy=0 in the same cycle, with no done. After release, a new start with 32'hDEADBEEF -> clean "DEADBEEF\r\n".
- Back-to-back: assert start with 32'hCAFEF00D in the done cycle -> next start bit begins in the following cycle (zero idle cycles); second frame decodes as 43 41 46 45 46 30 30 44 0D 0A.
